// File: rtl/eth_link_pkg.sv
// Shared definitions for the Ethernet link supervisor: FSM encoding, counter sizing
// and the saturating recovery-count helper.
package eth_link_pkg;

  typedef enum logic [2:0] {
    ST_WAIT_TX_DONE = 3'd0,
    ST_WAIT_RX_DONE = 3'd1,
    ST_WAIT_LOCK    = 3'd2,
    ST_LINK_UP      = 3'd3,
    ST_RX_RESET     = 3'd4,
    ST_FULL_RESET   = 3'd5
  } link_state_t;

  localparam int                 RETRY_W     = 8;
  localparam logic [RETRY_W-1:0] RETRY_MAX   = 8'd255;
  localparam int                 SYNC_STAGES = 2;

  // Bits needed to hold 0..max_val inclusive.
  function automatic int cnt_width(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

  function automatic logic [RETRY_W-1:0] sat_inc(input logic [RETRY_W-1:0] val);
    return (val == RETRY_MAX) ? val : val + 8'd1;
  endfunction

endpackage

// File: rtl/sync_bit.sv
// Multi-flop synchronizer for one asynchronous level into the local clock domain.
module sync_bit
  import eth_link_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [SYNC_STAGES-1:0] chain_r;

  // Shift the raw level through the synchronizer chain.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      chain_r <= '0;
    end else begin
      chain_r <= {chain_r[SYNC_STAGES-2:0], d};
    end
  end

  assign q = chain_r[SYNC_STAGES-1];

endmodule

// File: rtl/eth_link_supervisor.sv
// GT link bring-up supervisor: waits for reset-done and stable block lock, issues datapath
// resets on timeout and escalates to a full GT reset after repeated consecutive failures.
module eth_link_supervisor
  import eth_link_pkg::*;
#(
  parameter int LOCK_TIMEOUT_CYCLES = 12500000,
  parameter int LOCK_STABLE_CYCLES  = 1024,
  parameter int RESET_PULSE_CYCLES  = 16,
  parameter int MAX_RETRIES         = 8
) (
  input  logic               clk_125mhz_int,
  input  logic               gt_tx_reset,
  input  logic               gt_reset_tx_done,
  input  logic               gt_reset_rx_done,
  input  logic               rx_block_lock,
  output logic               gt_rx_datapath_reset,
  output logic               gt_reset_all,
  output logic               link_up,
  output logic [RETRY_W-1:0] retry_count,
  output logic [2:0]         state
);

  localparam int TW = cnt_width(LOCK_TIMEOUT_CYCLES);
  localparam int SW = cnt_width(LOCK_STABLE_CYCLES);
  localparam int FW = cnt_width(MAX_RETRIES);
  localparam logic [TW-1:0] TIMER_MAX    = TW'(LOCK_TIMEOUT_CYCLES);
  localparam logic [TW-1:0] TIMEOUT_LAST = TW'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [TW-1:0] PULSE_LAST   = TW'(RESET_PULSE_CYCLES - 1);
  localparam logic [SW-1:0] STABLE_LAST  = SW'(LOCK_STABLE_CYCLES - 1);
  localparam logic [FW-1:0] FAIL_LIMIT   = FW'(MAX_RETRIES);

  logic [1:0]         rst_pipe_r;
  logic               rst_int;
  logic               tx_done_s, rx_done_s, lock_s;
  link_state_t        state_r, state_nxt, fail_target_s;
  logic [TW-1:0]      timer_r, timer_nxt;
  logic [SW-1:0]      stable_r, stable_nxt;
  logic [FW-1:0]      fail_r, fail_nxt;
  logic [RETRY_W-1:0] retry_nxt;
  logic               timeout_s, pulse_done_s;
  logic               link_up_nxt, rx_reset_nxt, reset_all_nxt;

  // Reset asserts at once but releases two clocks later so every flop leaves reset together.
  always_ff @(posedge clk_125mhz_int or posedge gt_tx_reset) begin
    if (gt_tx_reset) begin
      rst_pipe_r <= 2'b11;
    end else begin
      rst_pipe_r <= {rst_pipe_r[0], 1'b0};
    end
  end

  assign rst_int = rst_pipe_r[1];

  sync_bit u_sync_tx   (.clk(clk_125mhz_int), .rst(rst_int), .d(gt_reset_tx_done), .q(tx_done_s));
  sync_bit u_sync_rx   (.clk(clk_125mhz_int), .rst(rst_int), .d(gt_reset_rx_done), .q(rx_done_s));
  sync_bit u_sync_lock (.clk(clk_125mhz_int), .rst(rst_int), .d(rx_block_lock),    .q(lock_s));

  assign timeout_s     = (timer_r == TIMEOUT_LAST);
  assign pulse_done_s  = (timer_r == PULSE_LAST);
  assign fail_target_s = (fail_r >= FAIL_LIMIT) ? ST_FULL_RESET : ST_RX_RESET;

  // State, counters and registered outputs.
  always_ff @(posedge clk_125mhz_int or posedge rst_int) begin
    if (rst_int) begin
      state_r              <= ST_WAIT_TX_DONE;
      timer_r              <= '0;
      stable_r             <= '0;
      fail_r               <= '0;
      retry_count          <= '0;
      link_up              <= 1'b0;
      gt_rx_datapath_reset <= 1'b0;
      gt_reset_all         <= 1'b0;
    end else begin
      state_r              <= state_nxt;
      timer_r              <= timer_nxt;
      stable_r             <= stable_nxt;
      fail_r               <= fail_nxt;
      retry_count          <= retry_nxt;
      link_up              <= link_up_nxt;
      gt_rx_datapath_reset <= rx_reset_nxt;
      gt_reset_all         <= reset_all_nxt;
    end
  end

  // Next state: pulse states run to completion, otherwise lost tx/rx done pre-empts the state rule.
  always_comb begin
    state_nxt = state_r;
    case (state_r)
      ST_RX_RESET: begin
        if (pulse_done_s) state_nxt = ST_WAIT_RX_DONE;
        else              state_nxt = state_r;
      end
      ST_FULL_RESET: begin
        if (pulse_done_s) state_nxt = ST_WAIT_TX_DONE;
        else              state_nxt = state_r;
      end
      ST_WAIT_TX_DONE: begin
        if (tx_done_s)      state_nxt = ST_WAIT_RX_DONE;
        else if (timeout_s) state_nxt = ST_FULL_RESET;
        else                state_nxt = state_r;
      end
      default: begin
        if (!tx_done_s) begin
          state_nxt = ST_WAIT_TX_DONE;
        end else if (!rx_done_s && (state_r != ST_WAIT_RX_DONE)) begin
          state_nxt = ST_WAIT_RX_DONE;
        end else begin
          case (state_r)
            ST_WAIT_RX_DONE: begin
              if (rx_done_s)      state_nxt = ST_WAIT_LOCK;
              else if (timeout_s) state_nxt = fail_target_s;
              else                state_nxt = state_r;
            end
            ST_WAIT_LOCK: begin
              if (lock_s && (stable_r == STABLE_LAST)) state_nxt = ST_LINK_UP;
              else if (timeout_s)                      state_nxt = fail_target_s;
              else                                     state_nxt = state_r;
            end
            ST_LINK_UP: begin
              if (!lock_s) state_nxt = ST_WAIT_LOCK;
              else         state_nxt = state_r;
            end
            default: state_nxt = ST_WAIT_TX_DONE;
          endcase
        end
      end
    endcase
  end

  // Counters: timer and stable count restart on any state change; retry bookkeeping on entry.
  always_comb begin
    fail_nxt   = fail_r;
    retry_nxt  = retry_count;
    stable_nxt = '0;
    if (state_nxt != state_r) begin
      timer_nxt = '0;
      case (state_nxt)
        ST_RX_RESET: begin
          fail_nxt  = fail_r + FW'(1);
          retry_nxt = sat_inc(retry_count);
        end
        ST_FULL_RESET: begin
          fail_nxt  = '0;
          retry_nxt = sat_inc(retry_count);
        end
        ST_LINK_UP: fail_nxt = '0;
        default:    fail_nxt = fail_r;
      endcase
    end else if (timer_r == TIMER_MAX) begin
      timer_nxt = timer_r;
    end else begin
      timer_nxt = timer_r + TW'(1);
    end
    if ((state_r == ST_WAIT_LOCK) && (state_nxt == ST_WAIT_LOCK) && lock_s) begin
      stable_nxt = stable_r + SW'(1);
    end else begin
      stable_nxt = '0;
    end
  end

  // Output decode from the next state so outputs register together with the state.
  always_comb begin
    link_up_nxt   = (state_nxt == ST_LINK_UP);
    rx_reset_nxt  = (state_nxt == ST_RX_RESET);
    reset_all_nxt = (state_nxt == ST_FULL_RESET);
  end

  assign state = state_r;

endmodule

// File: tb/tb_eth_link_supervisor.sv
// Randomized self-checking bench for eth_link_supervisor against a cycle-level model of the
// link rules, plus directed bring-up, relock, escalation, reset and saturation scenarios.
module tb_eth_link_supervisor;

  localparam int TO = 200;
  localparam int ST = 16;
  localparam int PU = 4;
  localparam int MR = 3;
  localparam int S_WTX = 0, S_WRX = 1, S_WL = 2, S_LU = 3, S_RXR = 4, S_FULL = 5;

  logic       clk = 1'b0;
  logic       rst, tx, rx, lk;
  logic       gt_rx_datapath_reset, gt_reset_all, link_up;
  logic [7:0] retry_count;
  logic [2:0] state;

  int total = 0;
  int bad   = 0;

  int m_st, m_tmr, m_stb, m_fail, m_retry, m_k, m_recov;
  logic [2:0] h1, h2;

  always #4 clk = ~clk;

  eth_link_supervisor #(
    .LOCK_TIMEOUT_CYCLES(TO),
    .LOCK_STABLE_CYCLES (ST),
    .RESET_PULSE_CYCLES (PU),
    .MAX_RETRIES        (MR)
  ) dut (
    .clk_125mhz_int      (clk),
    .gt_tx_reset         (rst),
    .gt_reset_tx_done    (tx),
    .gt_reset_rx_done    (rx),
    .rx_block_lock       (lk),
    .gt_rx_datapath_reset(gt_rx_datapath_reset),
    .gt_reset_all        (gt_reset_all),
    .link_up             (link_up),
    .retry_count         (retry_count),
    .state               (state)
  );

  task automatic finish_up();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: observed=%0h expected=%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_st = S_WTX; m_tmr = 0; m_stb = 0; m_fail = 0; m_retry = 0; m_k = 0;
    h1 = 3'b000; h2 = 3'b000;
  endtask

  function automatic int fail_pick();
    return (m_fail >= MR) ? S_FULL : S_RXR;
  endfunction

  // One clock edge of the reference: inputs reach the decision logic two edges after sampling,
  // and the core ignores two edges after reset release.
  task automatic model_edge();
    logic [2:0] s;
    int nx;
    bit tmo, pdone;
    if (rst) begin
      model_reset();
      return;
    end
    if (m_k < 2) begin
      m_k++;
      return;
    end
    s  = h2;
    h2 = h1;
    h1 = {tx, rx, lk};
    tmo   = (m_tmr + 1 >= TO);
    pdone = (m_tmr + 1 >= PU);
    nx = m_st;
    if (m_st == S_RXR) begin
      if (pdone) nx = S_WRX;
    end else if (m_st == S_FULL) begin
      if (pdone) nx = S_WTX;
    end else if (m_st == S_WTX) begin
      if (s[2]) nx = S_WRX;
      else if (tmo) nx = S_FULL;
    end else if (!s[2]) begin
      nx = S_WTX;
    end else if (!s[1] && m_st != S_WRX) begin
      nx = S_WRX;
    end else if (m_st == S_WRX) begin
      if (s[1]) nx = S_WL;
      else if (tmo) nx = fail_pick();
    end else if (m_st == S_WL) begin
      if (s[0] && m_stb + 1 >= ST) nx = S_LU;
      else if (tmo) nx = fail_pick();
    end else if (!s[0]) begin
      nx = S_WL;
    end
    m_stb = (m_st == S_WL && nx == S_WL && s[0]) ? m_stb + 1 : 0;
    if (nx != m_st) begin
      m_tmr = 0;
      if (nx == S_RXR || nx == S_FULL) begin
        m_recov++;
        if (m_retry < 255) m_retry++;
        m_fail = (nx == S_RXR) ? m_fail + 1 : 0;
      end
      if (nx == S_LU) m_fail = 0;
    end else begin
      m_tmr++;
    end
    m_st = nx;
  endtask

  task automatic cycle(input logic t, input logic r, input logic l);
    logic [2:0] ms;
    logic [7:0] mr;
    tx = t; rx = r; lk = l;
    @(posedge clk);
    model_edge();
    #1;
    ms = m_st[2:0];
    mr = m_retry[7:0];
    check("cycle", 32'({state, link_up, gt_rx_datapath_reset, gt_reset_all, retry_count}),
          32'({ms, (m_st == S_LU), (m_st == S_RXR), (m_st == S_FULL), mr}));
    if (bad >= 100) finish_up();
  endtask

  initial begin
    int lat, rx_w, all_w, n_rx, first_start, saved_retry;
    bit saw_low, done;
    logic t, r, l;
    int up_tx, up_rx, up_lk;

    rst = 1'b1; tx = 1'b0; rx = 1'b0; lk = 1'b0;
    model_reset();
    m_recov = 0;

    // reset state
    repeat (3) cycle(1'b0, 1'b0, 1'b0);
    check("rst_state", 32'(state), 32'd0);
    check("rst_retry", 32'(retry_count), 32'd0);

    // bring-up latency with everything ready
    rst = 1'b0;
    lat = 0;
    for (int i = 1; i <= 40; i++) begin
      cycle(1'b1, 1'b1, 1'b1);
      if (link_up && lat == 0) lat = i;
    end
    check("bringup_latency_window", 32'(lat >= 20 && lat <= 22), 32'd1);
    check("bringup_retry", 32'(retry_count), 32'd0);

    // single-cycle lock drop then relock
    saved_retry = int'(retry_count);
    cycle(1'b1, 1'b1, 1'b0);
    saw_low = !link_up;
    repeat (2) begin
      cycle(1'b1, 1'b1, 1'b1);
      if (!link_up) saw_low = 1'b1;
    end
    check("lock_drop_seen", 32'(saw_low), 32'd1);
    repeat (30) cycle(1'b1, 1'b1, 1'b1);
    check("relock_link_up", 32'(link_up), 32'd1);
    check("relock_retry", 32'(retry_count), 32'(saved_retry));

    // rx_done and lock lost together: rx_done wins
    repeat (4) cycle(1'b1, 1'b0, 1'b0);
    check("rx_lock_drop_state", 32'(state), 32'd1);
    repeat (30) cycle(1'b1, 1'b1, 1'b1);
    check("rx_lock_drop_relink", 32'(link_up), 32'd1);

    // lock stays low: datapath resets then escalation
    rx_w = 0; all_w = 0; n_rx = 0; first_start = 0; done = 1'b0;
    for (int i = 0; i < 2000 && !done; i++) begin
      cycle(1'b1, 1'b1, 1'b0);
      if (gt_rx_datapath_reset) begin
        if (rx_w == 0 && n_rx == 0) first_start = i;
        if (rx_w == 0 && n_rx == 1) check("rx_pulse_period", 32'(i - first_start), 32'(TO + PU + 1));
        rx_w++;
      end else if (rx_w > 0) begin
        check("rx_pulse_width", 32'(rx_w), 32'(PU));
        n_rx++;
        rx_w = 0;
      end
      if (gt_reset_all) begin
        all_w++;
      end else if (all_w > 0) begin
        check("full_pulse_width", 32'(all_w), 32'(PU));
        check("rx_pulses_before_full", 32'(n_rx), 32'(MR));
        check("retry_after_full", 32'(retry_count), 32'd4);
        done = 1'b1;
      end
    end
    check("full_reset_seen", 32'(done), 32'd1);

    // reset in the middle of a datapath reset pulse
    done = 1'b0;
    for (int i = 0; i < 1000 && !done; i++) begin
      cycle(1'b1, 1'b1, 1'b0);
      if (gt_rx_datapath_reset) begin
        cycle(1'b1, 1'b1, 1'b0);
        done = 1'b1;
      end
    end
    check("rx_pulse_reached", 32'(done), 32'd1);
    rst = 1'b1;
    model_reset();
    #1;
    check("midpulse_rx_reset", 32'(gt_rx_datapath_reset), 32'd0);
    check("midpulse_state", 32'(state), 32'd0);
    check("midpulse_retry", 32'(retry_count), 32'd0);
    repeat (2) cycle(1'b1, 1'b1, 1'b1);
    rst = 1'b0;

    // randomized regimes
    t = 1'b1; r = 1'b1; l = 1'b1;
    for (int seg = 0; seg < 8; seg++) begin
      up_tx = $urandom_range(2, 400);
      up_rx = $urandom_range(2, 300);
      up_lk = $urandom_range(2, 300);
      for (int i = 0; i < 500; i++) begin
        t = t ? ($urandom_range(0, 599) != 0) : ($urandom_range(0, up_tx) == 0);
        r = r ? ($urandom_range(0, 249) != 0) : ($urandom_range(0, up_rx) == 0);
        l = l ? ($urandom_range(0, 59) != 0)  : ($urandom_range(0, up_lk) == 0);
        rst = ($urandom_range(0, 2999) == 0);
        cycle(t, r, l);
      end
    end
    rst = 1'b0;

    // retry counter saturation
    rst = 1'b1;
    repeat (2) cycle(1'b1, 1'b1, 1'b0);
    rst = 1'b0;
    m_recov = 0;
    for (int i = 0; i < 70000 && m_recov < 300; i++) cycle(1'b1, 1'b1, 1'b0);
    check("recoveries_done", 32'(m_recov >= 300), 32'd1);
    check("retry_saturated", 32'(retry_count), 32'd255);

    finish_up();
  end

endmodule
